f_recode: RTL and testbench
===========================

F_RECODE -- requirements
Module: f_recode

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, all state on rising edge.
REQ-002 SHALL have port rst_l, input, 1 bit: asynchronous active-low reset.
REQ-003 SHALL have port in_valid, input, 1 bit: operand offered.
REQ-004 SHALL have port in_ready, output, 1 bit: operand accepted when in_valid && in_ready.
REQ-005 SHALL have port in_fp64, input, 1 bit: 1 = fp64 operand, 0 = fp32 operand in in_data[31:0], with in_data[63:32] ignored.
REQ-006 SHALL have port in_data, input, 64 bits: IEEE-754 operand.
REQ-007 SHALL have port flush, input, 1 bit: synchronous kill of all in-flight operands.
REQ-008 SHALL have port out_valid, output, 1 bit: result available.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts when out_valid && out_ready.
REQ-010 SHALL have port rec_fn, output, 65 bits: recoded result; fp64 {sign[64], exp[63:52] (12b), fract[51:0]}; fp32 {sign[32], exp[31:23] (9b), fract[22:0]}, bits [64:33] zero.
REQ-011 SHALL have port class_out, output, 10 bits: RISC-V fclass vector (bit0 -inf … bit9 qNaN), per REQ-026.

Function
REQ-012 SHALL implement the IEEE-to-recoded conversion, the inverse direction of the recoded-format classifier; E = 11 (fp64) / 8 (fp32), F = 52 / 23.
REQ-013 SHALL compute zExp = (exp==0), zFract = (fract==0), and normDist = leading-zero count of the F-bit fract field.
REQ-014 SHALL compute adj = zExp ? (~normDist, E+1 bits) : exp; then adj = adj + (2^(E-1) | (zExp ? 2 : 1)), modulo 2^(E+1).
REQ-015 SHALL set isSpecial = (adj[E:E-1]==2'b11) and isZero = zExp && zFract.
REQ-016 SHALL set out exp[E:E-2] = isSpecial ? {2'b11, !zFract} : isZero ? 3'b000 : adj[E:E-2], and out exp[E-3:0] = adj[E-3:0].
REQ-017 SHALL set out fract = zExp ? ((fract << normDist) << 1) truncated to F bits : fract; sign passes unchanged.
REQ-018 SHALL be a two-stage pipeline: S1 registers sign/exp/fract/fp64/zExp/zFract/normDist; S2 registers rec_fn and class_out.
REQ-019 Latency SHALL be exactly 2 cycles from the accept edge to out_valid with no back-pressure; throughput SHALL be 1 per cycle.
REQ-020 in_ready SHALL equal !s1_valid || !out_valid || out_ready (stage advances when downstream slot empty or draining); combinational, no dependency on in_valid.
REQ-021 While out_valid && !out_ready, rec_fn, class_out and out_valid SHALL hold stable.
REQ-022 Simultaneous output accept and input accept SHALL advance both stages in one cycle without loss or duplication.
REQ-023 Order SHALL be preserved; at most 2 operands in flight.
REQ-024 flush SHALL clear s1_valid and out_valid at the next edge, overriding any same-cycle accept; in_ready during flush follows REQ-020.

Reset
REQ-025 On rst_l low, asynchronously: s1_valid=0, out_valid=0, rec_fn=0, class_out=0; data registers SHALL be reset to 0; in_ready=1 after reset.

Configuration
REQ-026 Macro F_RECODE_CLASS_EN defined: class_out SHALL be registered in S2 alongside rec_fn, with bits {qNaN, sNaN, +inf, +norm, +sub, +zero, -zero, -sub, -norm, -inf} (bit9..bit0); qNaN/sNaN distinguished by fract MSB.
REQ-027 Macro F_RECODE_CLASS_EN undefined: class_out SHALL be tied to 10'h000 and no class registers synthesized.

Verification
REQ-028 fp32 0x3F800000 accepted, out_ready=1 -> out_valid 2 cycles later, rec_fn=65'h0_8000_0000, class_out=10'h040.
REQ-029 fp32 0x00000001 -> rec_fn=65'h0_3580_0000 (exp 9'h06B, fract 0), class_out=10'h020.
REQ-030 fp64 0x7FF0000000000000 -> rec_fn=65'h0_C000_0000_0000_0000, class_out=10'h080; fp64 0x7FF8000000000000 -> rec_fn=65'h0_E008_0000_0000_0000, class_out=10'h200.
REQ-031 Three back-to-back operands, out_ready=0 -> first two captured, in_ready=0 on third, outputs stable; raise out_ready -> three results in order, consecutive cycles.
REQ-032 flush asserted with two operands in flight -> out_valid=0 next cycle, no stale result emitted; rst_l pulsed mid-stream -> all outputs 0 immediately, in_ready=1.
REQ-033 Build without F_RECODE_CLASS_EN, repeat REQ-028 -> identical rec_fn, class_out=10'h000.

Source files
------------

// File: rtl/f_recode.sv
// rtl/f_recode.sv - two-stage IEEE-754 fp32/fp64 to recoded-format converter
// Optional RISC-V fclass vector on class_out when F_RECODE_CLASS_EN is defined.
module f_recode (
    input  logic        clk,
    input  logic        rst_l,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_fp64,
    input  logic [63:0] in_data,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [64:0] rec_fn,
    output logic [9:0]  class_out
);
    logic        r_s1_valid;
    logic        r_out_valid;
    logic        r_sign;
    logic [10:0] r_exp;
    logic [51:0] r_fract;
    logic        r_fp64;
    logic        r_zexp;
    logic        r_zfract;
    logic [5:0]  r_norm_dist;
    logic [64:0] r_rec_fn;

    logic        w_sign;
    logic [10:0] w_exp;
    logic [51:0] w_fract;
    logic [51:0] w_lzc_src;
    logic [5:0]  w_norm_dist;
    logic        w_in_accept;
    logic        w_s2_load;

    assign w_sign  = in_fp64 ? in_data[63] : in_data[31];
    assign w_exp   = in_fp64 ? in_data[62:52] : {3'b000, in_data[30:23]};
    assign w_fract = in_fp64 ? in_data[51:0] : {29'b0, in_data[22:0]};
    // fp32 fract is left-aligned with a sentinel one so an all-zero field counts exactly 23
    assign w_lzc_src = in_fp64 ? in_data[51:0] : {in_data[22:0], 1'b1, 28'b0};

    always_comb begin
        w_norm_dist = 6'd52;
        for (int i = 0; i < 52; i++) begin
            if (w_lzc_src[i]) w_norm_dist = 6'(51 - i);
        end
    end

    assign in_ready    = !r_s1_valid || !r_out_valid || out_ready;
    assign w_in_accept = in_valid && in_ready;
    assign w_s2_load   = r_s1_valid && (!r_out_valid || out_ready);

    // Stage 2 combinational recode from the stage 1 fields
    logic        w_is_zero;
    logic [11:0] w_adj64_base;
    logic [11:0] w_adj64;
    logic [11:0] w_exp64;
    logic [51:0] w_fract64;
    logic [8:0]  w_adj32_base;
    logic [8:0]  w_adj32;
    logic [8:0]  w_exp32;
    logic [22:0] w_fract32;
    logic [64:0] w_rec;

    assign w_is_zero    = r_zexp && r_zfract;
    assign w_adj64_base = r_zexp ? ~{6'b0, r_norm_dist} : {1'b0, r_exp};
    assign w_adj64      = w_adj64_base + (12'h400 | (r_zexp ? 12'd2 : 12'd1));
    assign w_exp64[11:9] = (&w_adj64[11:10]) ? {2'b11, !r_zfract} :
                           w_is_zero ? 3'b000 : w_adj64[11:9];
    assign w_exp64[8:0]  = w_adj64[8:0];
    assign w_fract64    = r_zexp ? ({r_fract[50:0], 1'b0} << r_norm_dist) : r_fract;

    assign w_adj32_base = r_zexp ? ~{3'b0, r_norm_dist} : {1'b0, r_exp[7:0]};
    assign w_adj32      = w_adj32_base + (9'h080 | (r_zexp ? 9'd2 : 9'd1));
    assign w_exp32[8:6] = (&w_adj32[8:7]) ? {2'b11, !r_zfract} :
                          w_is_zero ? 3'b000 : w_adj32[8:6];
    assign w_exp32[5:0] = w_adj32[5:0];
    assign w_fract32    = r_zexp ? ({r_fract[21:0], 1'b0} << r_norm_dist) : r_fract[22:0];

    assign w_rec = r_fp64 ? {r_sign, w_exp64, w_fract64}
                          : {32'b0, r_sign, w_exp32, w_fract32};

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_s1_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_sign      <= 1'b0;
            r_exp       <= '0;
            r_fract     <= '0;
            r_fp64      <= 1'b0;
            r_zexp      <= 1'b0;
            r_zfract    <= 1'b0;
            r_norm_dist <= '0;
            r_rec_fn    <= '0;
        end else begin
            if (flush) begin
                r_s1_valid  <= 1'b0;
                r_out_valid <= 1'b0;
            end else begin
                if (w_in_accept)    r_s1_valid <= 1'b1;
                else if (w_s2_load) r_s1_valid <= 1'b0;
                if (!r_out_valid || out_ready) r_out_valid <= r_s1_valid;
            end
            if (w_in_accept) begin
                r_sign      <= w_sign;
                r_exp       <= w_exp;
                r_fract     <= w_fract;
                r_fp64      <= in_fp64;
                r_zexp      <= (w_exp == 11'd0);
                r_zfract    <= (w_fract == 52'd0);
                r_norm_dist <= w_norm_dist;
            end
            if (w_s2_load) r_rec_fn <= w_rec;
        end
    end

    assign out_valid = r_out_valid;
    assign rec_fn    = r_rec_fn;

`ifdef F_RECODE_CLASS_EN
    logic       w_exp_ones;
    logic       w_fract_msb;
    logic       w_is_inf;
    logic       w_is_nan;
    logic       w_is_sub;
    logic       w_is_norm;
    logic [9:0] w_class;
    logic [9:0] r_class;

    assign w_exp_ones  = r_fp64 ? (&r_exp) : (&r_exp[7:0]);
    assign w_fract_msb = r_fp64 ? r_fract[51] : r_fract[22];
    assign w_is_inf    = w_exp_ones && r_zfract;
    assign w_is_nan    = w_exp_ones && !r_zfract;
    assign w_is_sub    = r_zexp && !r_zfract;
    assign w_is_norm   = !r_zexp && !w_exp_ones;
    assign w_class = {w_is_nan && w_fract_msb, w_is_nan && !w_fract_msb,
                      w_is_inf && !r_sign, w_is_norm && !r_sign,
                      w_is_sub && !r_sign, w_is_zero && !r_sign,
                      w_is_zero && r_sign, w_is_sub && r_sign,
                      w_is_norm && r_sign, w_is_inf && r_sign};

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l)         r_class <= '0;
        else if (w_s2_load) r_class <= w_class;
    end

    assign class_out = r_class;
`else
    assign class_out = 10'h000;
`endif
endmodule

// File: tb/tb_f_recode.sv
// tb/tb_f_recode.sv - directed self-checking bench for f_recode
module tb_f_recode;
    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_fp64 = 1'b0;
    logic [63:0] in_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [64:0] rec_fn;
    logic [9:0]  class_out;

    int n_vec = 0;
    int n_err = 0;

    f_recode dut (
        .clk(clk), .rst_l(rst_l), .in_valid(in_valid), .in_ready(in_ready),
        .in_fp64(in_fp64), .in_data(in_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .rec_fn(rec_fn), .class_out(class_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] xc(input logic [9:0] c);
`ifdef F_RECODE_CLASS_EN
        return c;
`else
        return 10'h000;
`endif
    endfunction

    task automatic send_one(input string tag, input logic f64, input logic [63:0] d,
                            input logic [64:0] er, input logic [9:0] ec);
        @(negedge clk);
        in_valid = 1'b1; in_fp64 = f64; in_data = d; out_ready = 1'b1;
        #1 chk({tag, "_rdy"}, 65'(in_ready), 65'd1);
        @(negedge clk);
        in_valid = 1'b0; in_data = '0;
        chk({tag, "_lat1"}, 65'(out_valid), 65'd0);
        @(negedge clk);
        chk({tag, "_vld"}, 65'(out_valid), 65'd1);
        chk({tag, "_rec"}, rec_fn, er);
        chk({tag, "_cls"}, 65'(class_out), 65'(xc(ec)));
        @(negedge clk);
        chk({tag, "_drain"}, 65'(out_valid), 65'd0);
    endtask

    initial begin
        #2;
        chk("rst_vld", 65'(out_valid), 65'd0);
        chk("rst_rec", rec_fn, 65'd0);
        chk("rst_cls", 65'(class_out), 65'd0);
        chk("rst_rdy", 65'(in_ready), 65'd1);
        @(negedge clk);
        rst_l = 1'b1;

        send_one("one32",  1'b0, 64'h0000_0000_3F80_0000, 65'h0_0000_0000_8000_0000, 10'h040);
        send_one("sub32",  1'b0, 64'h0000_0000_0000_0001, 65'h0_0000_0000_3580_0000, 10'h020);
        send_one("inf64",  1'b1, 64'h7FF0_0000_0000_0000, 65'h0_C000_0000_0000_0000, 10'h080);
        send_one("qnan64", 1'b1, 64'h7FF8_0000_0000_0000, 65'h0_E008_0000_0000_0000, 10'h200);
        send_one("nzero32",1'b0, 64'hDEAD_BEEF_8000_0000, 65'h1_1500_0000, 10'h008);
        send_one("mone64", 1'b1, 64'hBFF0_0000_0000_0000, 65'h1_8000_0000_0000_0000, 10'h002);
        send_one("snan32", 1'b0, 64'h0000_0000_7F80_0001, 65'h0_0000_0000_E000_0001, 10'h100);
        send_one("ninf32", 1'b0, 64'h0000_0000_FF80_0000, 65'h1_C000_0000, 10'h001);
        send_one("nsub64", 1'b1, 64'h8000_0000_0000_0003, 65'h1_3CF8_0000_0000_0000, 10'h004);
        send_one("zero64", 1'b1, 64'h0000_0000_0000_0000, 65'h0_1CD0_0000_0000_0000, 10'h010);

        // back-pressure: three back-to-back operands, only two fit
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_fp64 = 1'b0; in_data = 64'h3F80_0000;
        #1 chk("bp_rdyA", 65'(in_ready), 65'd1);
        @(negedge clk);
        in_data = 64'h0000_0001;
        #1 chk("bp_rdyB", 65'(in_ready), 65'd1);
        @(negedge clk);
        in_data = 64'h4000_0000;
        #1 chk("bp_rdyC", 65'(in_ready), 65'd0);
        chk("bp_vA", 65'(out_valid), 65'd1);
        chk("bp_recA", rec_fn, 65'h0_8000_0000);
        @(negedge clk);
        chk("bp_holdV", 65'(out_valid), 65'd1);
        chk("bp_holdA", rec_fn, 65'h0_8000_0000);
        chk("bp_holdC", 65'(class_out), 65'(xc(10'h040)));
        out_ready = 1'b1;
        #1 chk("bp_rdyC2", 65'(in_ready), 65'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_vB", 65'(out_valid), 65'd1);
        chk("bp_recB", rec_fn, 65'h0_3580_0000);
        @(negedge clk);
        chk("bp_vC", 65'(out_valid), 65'd1);
        chk("bp_recC", rec_fn, 65'h0_8080_0000);
        @(negedge clk);
        chk("bp_done", 65'(out_valid), 65'd0);

        // flush with two in flight and a same-cycle offered operand
        out_ready = 1'b0; in_valid = 1'b1; in_data = 64'h3F80_0000;
        @(negedge clk);
        in_data = 64'h4000_0000;
        @(negedge clk);
        chk("fl_pre", 65'(out_valid), 65'd1);
        in_data = 64'h0000_0001; out_ready = 1'b1; flush = 1'b1;
        #1 chk("fl_rdy", 65'(in_ready), 65'd1);
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        chk("fl_vld0", 65'(out_valid), 65'd0);
        chk("fl_rdy1", 65'(in_ready), 65'd1);
        @(negedge clk);
        chk("fl_vld1", 65'(out_valid), 65'd0);
        @(negedge clk);
        chk("fl_vld2", 65'(out_valid), 65'd0);

        // asynchronous reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1; in_fp64 = 1'b1; in_data = 64'h7FF0_0000_0000_0000;
        @(negedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        chk("ar_pre", 65'(out_valid), 65'd1);
        #2 rst_l = 1'b0;
        #1;
        chk("ar_vld", 65'(out_valid), 65'd0);
        chk("ar_rec", rec_fn, 65'd0);
        chk("ar_cls", 65'(class_out), 65'd0);
        chk("ar_rdy", 65'(in_ready), 65'd1);
        @(negedge clk);
        rst_l = 1'b1;

        send_one("post", 1'b0, 64'h0000_0000_3F80_0000, 65'h0_8000_0000, 10'h040);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
